// File: rtl/lsu_store_align.sv
// Store alignment stage: places an LSB-justified store onto bus byte lanes, builds the
// byte-write mask and splits line-crossing stores into two valid/ready bus beats.
module lsu_store_align #(
  parameter int unsigned LLEN    = 64,
  parameter int unsigned PA_BITS = 34
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ReqValid,
  output logic               ReqReady,
  input  logic [PA_BITS-1:0] ReqAdr,
  input  logic [1:0]         ReqSize,
  input  logic [LLEN-1:0]    ReqData,
  input  logic               Flush,
  output logic               BusValid,
  input  logic               BusReady,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [LLEN-1:0]    BusData,
  output logic [LLEN/8-1:0]  BusByteMask,
  output logic               BusLast,
  output logic               Busy
);

  localparam int unsigned NB   = LLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned CW   = OFFW + 2;

  typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;

  state_t state, state_nxt;
  logic   load_req, load_b1;

  logic [1:0]         size_cl;
  logic [OFFW-1:0]    off;
  logic [2*LLEN-1:0]  wide_data;
  logic [2*NB-1:0]    ones, wide_mask;
  logic [CW-1:0]      lane_end;
  logic               split;
  logic [PA_BITS-1:0] adr0, adr1;

  logic               split_q;
  logic [PA_BITS-1:0] b1_adr;
  logic [LLEN-1:0]    b1_data;
  logic [NB-1:0]      b1_mask;

  logic bus_fire, accept;

  // Lane placement of the incoming request; size clamps to the bus width
  assign size_cl   = (ReqSize > 2'(OFFW)) ? 2'(OFFW) : ReqSize;
  assign off       = ReqAdr[OFFW-1:0];
  assign wide_data = {{LLEN{1'b0}}, ReqData} << {off, 3'b000};
  assign ones      = ((2*NB)'(1) << (4'(1) << size_cl)) - (2*NB)'(1);
  assign wide_mask = ones << off;
  assign lane_end  = CW'(off) + (CW'(1) << size_cl);
  assign split     = lane_end > CW'(NB);
  assign adr0      = {ReqAdr[PA_BITS-1:OFFW], OFFW'(0)};
  assign adr1      = adr0 + PA_BITS'(NB);

  assign BusValid = (state != IDLE);
  assign Busy     = (state != IDLE);
  assign bus_fire = BusValid & BusReady;
  // Ready while the last beat retires so stores stream without a bubble
  assign ReqReady = (state == IDLE) | (bus_fire & BusLast & ~Flush);
  assign accept   = ReqValid & ReqReady;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    load_b1   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_req  = 1'b1;
          state_nxt = SEND0;
        end
      end
      SEND0: begin
        if (Flush) begin
          state_nxt = IDLE;
        end else if (bus_fire) begin
          if (split_q) begin
            load_b1   = 1'b1;
            state_nxt = SEND1;
          end else if (accept) begin
            load_req  = 1'b1;
            state_nxt = SEND0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      SEND1: begin
        if (Flush) begin
          state_nxt = IDLE;
        end else if (bus_fire) begin
          if (accept) begin
            load_req  = 1'b1;
            state_nxt = SEND0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat registers only change on a load, so they hold under backpressure
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      BusAdr      <= '0;
      BusData     <= '0;
      BusByteMask <= '0;
      BusLast     <= 1'b0;
      split_q     <= 1'b0;
      b1_adr      <= '0;
      b1_data     <= '0;
      b1_mask     <= '0;
    end else if (load_req) begin
      BusAdr      <= adr0;
      BusData     <= wide_data[LLEN-1:0];
      BusByteMask <= wide_mask[NB-1:0];
      BusLast     <= ~split;
      split_q     <= split;
      b1_adr      <= adr1;
      b1_data     <= wide_data[2*LLEN-1:LLEN];
      b1_mask     <= wide_mask[2*NB-1:NB];
    end else if (load_b1) begin
      BusAdr      <= b1_adr;
      BusData     <= b1_data;
      BusByteMask <= b1_mask;
      BusLast     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_store_align.sv
// Directed bench for lsu_store_align (LLEN=64, PA_BITS=34) with hand-computed expectations.
module tb_lsu_store_align;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ReqValid, ReqReady;
  logic [33:0] ReqAdr;
  logic [1:0]  ReqSize;
  logic [63:0] ReqData;
  logic        Flush;
  logic        BusValid, BusReady;
  logic [33:0] BusAdr;
  logic [63:0] BusData;
  logic [7:0]  BusByteMask;
  logic        BusLast, Busy;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_store_align #(.LLEN(64), .PA_BITS(34)) dut (
    .clk(clk), .reset_n(reset_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAdr(ReqAdr), .ReqSize(ReqSize),
    .ReqData(ReqData), .Flush(Flush),
    .BusValid(BusValid), .BusReady(BusReady), .BusAdr(BusAdr), .BusData(BusData),
    .BusByteMask(BusByteMask), .BusLast(BusLast), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic beat(input string tag, input logic [33:0] adr, input logic [7:0] mask,
                      input logic [63:0] data, input logic last);
    check({tag, ".valid"}, 128'(BusValid), 128'(1));
    check({tag, ".adr"},   128'(BusAdr), 128'(adr));
    check({tag, ".mask"},  128'(BusByteMask), 128'(mask));
    check({tag, ".data"},  128'(BusData), 128'(data));
    check({tag, ".last"},  128'(BusLast), 128'(last));
  endtask

  task automatic req(input logic [33:0] adr, input logic [1:0] size, input logic [63:0] data);
    ReqValid = 1'b1; ReqAdr = adr; ReqSize = size; ReqData = data;
  endtask

  initial begin
    reset_n = 1'b0; ReqValid = 1'b0; ReqAdr = '0; ReqSize = '0; ReqData = '0;
    Flush = 1'b0; BusReady = 1'b0;
    #12;
    check("rst.valid", 128'(BusValid), 128'(0));
    check("rst.busy",  128'(Busy), 128'(0));
    check("rst.ready", 128'(ReqReady), 128'(1));
    check("rst.mask",  128'(BusByteMask), 128'(0));
    check("rst.adr",   128'(BusAdr), 128'(0));
    check("rst.data",  128'(BusData), 128'(0));
    check("rst.last",  128'(BusLast), 128'(0));
    cyc(); reset_n = 1'b1;

    // Byte store, single beat
    cyc(); req(34'h1003, 2'd0, 64'hAB); #1;
    check("byte.ready_idle", 128'(ReqReady), 128'(1));
    cyc(); ReqValid = 1'b0; #1;
    beat("byte", 34'h1000, 8'h08, 64'hAB00_0000, 1'b1);
    check("byte.busy", 128'(Busy), 128'(1));
    check("byte.ready_stall", 128'(ReqReady), 128'(0));
    BusReady = 1'b1; #1;
    check("byte.ready_fire", 128'(ReqReady), 128'(1));
    cyc(); BusReady = 1'b0; #1;
    check("byte.done", 128'(BusValid), 128'(0));

    // Split word store with 3 cycles of backpressure in SEND0
    cyc(); req(34'h1006, 2'd2, 64'hDDCC_BBAA);
    cyc(); ReqValid = 1'b0; #1;
    beat("split.b0", 34'h1000, 8'hC0, 64'hBBAA_0000_0000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      beat("bp.b0", 34'h1000, 8'hC0, 64'hBBAA_0000_0000_0000, 1'b0);
      check("bp.ready", 128'(ReqReady), 128'(0));
    end
    BusReady = 1'b1; #1;
    check("split.b0_ready", 128'(ReqReady), 128'(0));
    cyc(); #1;
    beat("split.b1", 34'h1008, 8'h03, 64'hDDCC, 1'b1);
    check("split.b1_ready", 128'(ReqReady), 128'(1));
    cyc(); BusReady = 1'b0; #1;
    check("split.done", 128'(BusValid), 128'(0));

    // Back-to-back aligned dwords, one beat per cycle
    cyc(); BusReady = 1'b1; req(34'h0, 2'd3, 64'h1111_2222_3333_4444);
    cyc(); req(34'h8, 2'd3, 64'h5555_6666_7777_8888); #1;
    beat("b2b.0", 34'h0, 8'hFF, 64'h1111_2222_3333_4444, 1'b1);
    check("b2b.ready0", 128'(ReqReady), 128'(1));
    cyc(); req(34'h10, 2'd3, 64'h9999_AAAA_BBBB_CCCC); #1;
    beat("b2b.1", 34'h8, 8'hFF, 64'h5555_6666_7777_8888, 1'b1);
    cyc(); ReqValid = 1'b0; #1;
    beat("b2b.2", 34'h10, 8'hFF, 64'h9999_AAAA_BBBB_CCCC, 1'b1);
    cyc(); #1;
    check("b2b.done", 128'(BusValid), 128'(0));

    // Flush in SEND1 drops beat1
    cyc(); req(34'h1006, 2'd2, 64'hDDCC_BBAA);
    cyc(); ReqValid = 1'b0; #1;
    beat("fl.b0", 34'h1000, 8'hC0, 64'hBBAA_0000_0000_0000, 1'b0);
    cyc(); BusReady = 1'b0; Flush = 1'b1; #1;
    check("fl.send1_adr", 128'(BusAdr), 128'(34'h1008));
    check("fl.ready", 128'(ReqReady), 128'(0));
    cyc(); Flush = 1'b0; #1;
    check("fl.valid", 128'(BusValid), 128'(0));
    check("fl.busy", 128'(Busy), 128'(0));
    cyc(); #1;
    check("fl.stay_idle", 128'(BusValid), 128'(0));

    // Address wrap on beat1
    BusReady = 1'b1;
    cyc(); req(34'h3_FFFF_FFFC, 2'd3, 64'h1122_3344_5566_7788);
    cyc(); ReqValid = 1'b0; #1;
    beat("wrap.b0", 34'h3_FFFF_FFF8, 8'hF0, 64'h5566_7788_0000_0000, 1'b0);
    cyc(); #1;
    beat("wrap.b1", 34'h0, 8'h0F, 64'h1122_3344, 1'b1);
    cyc(); BusReady = 1'b0; #1;
    check("wrap.done", 128'(BusValid), 128'(0));

    // Asynchronous reset during SEND0
    cyc(); req(34'h2001, 2'd1, 64'h5A5A);
    cyc(); ReqValid = 1'b0; #1;
    beat("ar.b0", 34'h2000, 8'h06, 64'h5A_5A00, 1'b1);
    reset_n = 1'b0; #1;
    check("ar.valid", 128'(BusValid), 128'(0));
    check("ar.mask",  128'(BusByteMask), 128'(0));
    check("ar.busy",  128'(Busy), 128'(0));
    cyc(); reset_n = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
